pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer; next generation of the single-jump PC.
//  Adds relative branch, subroutine call/return through an internal return-address
//  stack, a global stall gate and sticky stack-error flags.
//  Sits between the instruction decoder (control inputs) and instruction memory
//  address port (PCout).
// PARAMETERS
//  ADDR_W       9   PC / address width in bits (>=2)
//  STACK_DEPTH  4   return-address stack entries (>=1)
//  RESET_VEC    0   PC value loaded on reset (ADDR_W bits)
// PORTS
//  clk           in   1                    clock, all state updates on posedge
//  reset         in   1                    async active-high reset
//  enablePC      in   1                    0 = stall: PC, stack, flags all hold
//  load_PC       in   1                    sequential advance, PC <= PC+1
//  jump_en       in   1                    absolute jump request
//  jump_addr     in   ADDR_W               jump target
//  branch_en     in   1                    relative branch request
//  branch_off    in   ADDR_W               two's-complement offset from current PC
//  call_en       in   1                    call: push PC+1, PC <= jump_addr
//  ret_en        in   1                    return: PC <= pop
//  err_clr       in   1                    clears sticky error flags
//  PCout         out  ADDR_W               current PC (registered)
//  stack_level   out  $clog2(STACK_DEPTH+1) entries in use (registered)
//  stack_ovf     out  1                    sticky: call attempted while full
//  stack_unf     out  1                    sticky: return attempted while empty
// BEHAVIOUR
//  Reset (async, immediate): PCout=RESET_VEC, stack_level=0, stack_ovf=0,
//   stack_unf=0; stack contents don't-care. Removal synchronous to clk.
//  All outputs registered; a request sampled at edge N is visible after edge N.
//  enablePC=0: everything holds, including err_clr (ignored while stalled).
//  Priority when enablePC=1 (only the winner acts, the rest are ignored):
//   call_en > ret_en > jump_en > branch_en > load_PC > hold.
//  call: level<DEPTH -> stack[level]<=PC+1 (mod 2^ADDR_W), level+1,
//   PC<=jump_addr. level==DEPTH -> no push, PC holds, stack_ovf<=1.
//  ret: level>0 -> PC<=stack[level-1], level-1. level==0 -> PC holds,
//   stack_unf<=1.
//  jump: PC<=jump_addr. Stack untouched.
//  branch: PC<=PC+branch_off, ADDR_W-bit modular arithmetic (wraps both ways).
//  load_PC: PC<=PC+1; all-ones wraps to 0.
//  Stack is LIFO; pushes/pops are the only way level changes; no simultaneous
//   push+pop (priority guarantees).
//  err_clr (enablePC=1): both flags <=0 unless the same edge sets one; set wins.
//  Flags stay set until err_clr or reset; they never block operation.
// TESTING
//  Reset mid-run with PC=0x1A5, level=2, ovf=1 -> PCout=RESET_VEC, level=0,
//   flags 0 without waiting for clk.
//  PC=0x1FF, load_PC 1 cycle -> PC=0x000; branch_off=0x1FE from PC=0x001 -> 0x1FF.
//  PC=0x010, call jump_addr=0x080 -> PC=0x080, level=1; ret -> PC=0x011, level=0.
//  DEPTH=4: 4 nested calls then 5th call -> PC holds, level=4, stack_ovf=1;
//   4 rets return in reverse order; 5th ret -> PC holds, stack_unf=1.
//  call_en+ret_en+jump_en+load_PC same cycle -> call only; jump_en+load_PC ->
//   jump only; enablePC=0 with all requests high -> no state change.
//  ovf=1, err_clr with a 5th overflowing call same edge -> ovf stays 1;
//   err_clr alone next cycle -> ovf=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with sequential advance, absolute jump, relative branch,
// call/return through a return-address stack, stall gating and sticky stack-error flags.
module pc_sequencer #(
  parameter int                ADDR_W      = 9,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}}
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enablePC,
  input  logic                               load_PC,
  input  logic                               jump_en,
  input  logic [ADDR_W-1:0]                  jump_addr,
  input  logic                               branch_en,
  input  logic [ADDR_W-1:0]                  branch_off,
  input  logic                               call_en,
  input  logic                               ret_en,
  input  logic                               err_clr,
  output logic [ADDR_W-1:0]                  PCout,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  localparam int                LVL_W    = $clog2(STACK_DEPTH + 1);
  // Array sized to the full index range so the level register indexes it without truncation.
  localparam int                SLOTS    = 2 ** LVL_W;
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(STACK_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ZERO = LVL_W'(0);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] stack_r [SLOTS];
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] pc_nxt_s;
  logic [LVL_W-1:0]  lvl_nxt_s;
  logic [LVL_W-1:0]  lvl_dec_s;
  logic              ovf_nxt_s;
  logic              unf_nxt_s;
  logic              push_s;

  assign pc_inc_s  = PCout + PC_ONE;
  assign lvl_dec_s = stack_level - LVL_ONE;

  // Next-state selection: call > ret > jump > branch > load_PC > hold, all gated by enablePC.
  always_comb begin
    pc_nxt_s  = PCout;
    lvl_nxt_s = stack_level;
    ovf_nxt_s = stack_ovf;
    unf_nxt_s = stack_unf;
    push_s    = 1'b0;
    if (enablePC) begin
      if (err_clr) begin
        ovf_nxt_s = 1'b0;
        unf_nxt_s = 1'b0;
      end else begin
        ovf_nxt_s = stack_ovf;
        unf_nxt_s = stack_unf;
      end
      if (call_en) begin
        if (stack_level != FULL_LVL) begin
          push_s    = 1'b1;
          lvl_nxt_s = stack_level + LVL_ONE;
          pc_nxt_s  = jump_addr;
        end else begin
          ovf_nxt_s = 1'b1;
        end
      end else if (ret_en) begin
        if (stack_level != LVL_ZERO) begin
          lvl_nxt_s = lvl_dec_s;
          pc_nxt_s  = stack_r[lvl_dec_s];
        end else begin
          unf_nxt_s = 1'b1;
        end
      end else if (jump_en) begin
        pc_nxt_s = jump_addr;
      end else if (branch_en) begin
        pc_nxt_s = PCout + branch_off;
      end else if (load_PC) begin
        pc_nxt_s = pc_inc_s;
      end else begin
        pc_nxt_s = PCout;
      end
    end else begin
      pc_nxt_s = PCout;
    end
  end

  // Architectural state registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PCout       <= RESET_VEC;
      stack_level <= LVL_ZERO;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      PCout       <= pc_nxt_s;
      stack_level <= lvl_nxt_s;
      stack_ovf   <= ovf_nxt_s;
      stack_unf   <= unf_nxt_s;
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[stack_level] <= pc_inc_s;
    end else begin
      stack_r[stack_level] <= stack_r[stack_level];
    end
  end

endmodule
